// File: rtl/twiddle_loader_pkg.sv
// Shared constants and FSM encoding for the twiddle table loader.
package twiddle_loader_pkg;

  // log2 of the FFT size; the twiddle table holds N/2 entries
  localparam int TWL_C2LOG_FFT_POINTS = 4;
  // width of each real/imag component, two's complement
  localparam int TWL_DATA_IN_WIDTH    = 16;

  typedef enum logic [1:0] {
    TWL_IDLE  = 2'd0,
    TWL_LOAD  = 2'd1,
    TWL_FLUSH = 2'd2
  } twl_state_e;

endpackage

// File: rtl/twiddle_loader_sat_neg.sv
// Saturating two's complement negate: the most negative code maps to the
// most positive one instead of wrapping back onto itself.
module tw_sat_neg
  import twiddle_loader_pkg::*;
#(
  parameter int DATA_W = TWL_DATA_IN_WIDTH
) (
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  // negate, clamping -2^(DATA_W-1) to 2^(DATA_W-1)-1
  always_comb begin
    if (din == MOST_NEG) dout = ~MOST_NEG;
    else                 dout = -din;
  end

endmodule

// File: rtl/twiddle_loader.sv
// Streamed writer for the R2SDF twiddle RAM: accepts one {re,im} word per
// table entry over valid/ready and writes entries 0..DEPTH-1 in order.
// Optional macro TW_LOAD_CONJ_EN adds a conj input that loads the
// conjugate (IFFT) table with a saturated negated imaginary part.
//
// state      | meaning
// TWL_IDLE   | waiting for start, stream not consumed
// TWL_LOAD   | s_ready high, one entry accepted per transfer
// TWL_FLUSH  | final write presented, done pulse, table_ok set
module twiddle_loader
  import twiddle_loader_pkg::*;
#(
  parameter int ADDR_W = TWL_C2LOG_FFT_POINTS - 1,
  parameter int DATA_W = TWL_DATA_IN_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
`ifdef TW_LOAD_CONJ_EN
  input  logic                conj,
`endif
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [2*DATA_W-1:0] s_data,
  output logic                tw_we,
  output logic [ADDR_W-1:0]   tw_waddr,
  output logic [DATA_W-1:0]   tw_wre,
  output logic [DATA_W-1:0]   tw_wim,
  output logic                busy,
  output logic                done,
  output logic                table_ok
);

  twl_state_e state, state_nxt;

  logic [ADDR_W-1:0] cnt;
  logic              xfer;
  logic              wr_take;
  logic              load_go;
  logic              cnt_last;
  logic [DATA_W-1:0] s_re;
  logic [DATA_W-1:0] s_im;
  logic [DATA_W-1:0] im_w;

  assign s_re     = s_data[2*DATA_W-1:DATA_W];
  assign s_im     = s_data[DATA_W-1:0];
  assign xfer     = s_valid & s_ready;
  // a transfer coinciding with abort is dropped
  assign wr_take  = xfer & ~abort;
  assign load_go  = (state == TWL_IDLE) & start & ~abort;
  assign cnt_last = (cnt == {ADDR_W{1'b1}});

`ifdef TW_LOAD_CONJ_EN
  logic              conj_q;
  logic [DATA_W-1:0] im_neg;

  tw_sat_neg #(.DATA_W(DATA_W)) u_sat_neg (
    .din  (s_im),
    .dout (im_neg)
  );

  assign im_w = conj_q ? im_neg : s_im;

  // conj is captured when a load begins and held until the next one
  always_ff @(posedge clk) begin
    if (rst)          conj_q <= 1'b0;
    else if (load_go) conj_q <= conj;
  end
`else
  assign im_w = s_im;
`endif

  // next state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      TWL_IDLE: begin
        if (load_go) state_nxt = TWL_LOAD;
      end
      TWL_LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (abort)                  state_nxt = TWL_IDLE;
        else if (xfer && cnt_last)  state_nxt = TWL_FLUSH;
      end
      TWL_FLUSH: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = TWL_IDLE;
      end
      default: state_nxt = TWL_IDLE;
    endcase
  end

  // state register, address counter, registered write port and table flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= TWL_IDLE;
      cnt      <= '0;
      tw_we    <= 1'b0;
      tw_waddr <= '0;
      tw_wre   <= '0;
      tw_wim   <= '0;
      table_ok <= 1'b0;
    end else begin
      state <= state_nxt;
      tw_we <= wr_take;
      if (wr_take) begin
        tw_waddr <= cnt;
        tw_wre   <= s_re;
        tw_wim   <= im_w;
        cnt      <= cnt + 1'b1;
      end
      if (load_go) begin
        cnt      <= '0;
        table_ok <= 1'b0;
      end else if (wr_take && cnt_last) begin
        table_ok <= 1'b1;
      end
    end
  end

endmodule
